// File: rtl/fft_pkg.sv
// Shared constants and helpers for the FFT output reorder path.
package fft_pkg;

  localparam int DEF_N     = 128;
  localparam int DEF_WIDTH = 16;
  localparam int MAX_NN    = 12;

  function automatic int clog2c(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [MAX_NN-1:0] bitrev(input logic [MAX_NN-1:0] v, input int w);
    logic [MAX_NN-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_NN; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on contents.
module fft_reorder_ram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Converts the bit-reversed frame stream of the FFT core into natural order
// through a ping-pong buffer, with no input stall and no gap between frames.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic             do_first
);

  localparam int NN = clog2c(N);

  logic [NN-1:0] wr_cnt_q, wr_cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic [NN-1:0] rd_cnt_q, rd_cnt_d;
  logic          rd_bank_q, rd_bank_d;
  logic [1:0]    full_q, full_d;
  logic          rd_active_q, rd_active_d;

  logic [MAX_NN-1:0] wr_rev_full;
  logic [NN-1:0]     wr_rev;
  logic              wr_done, wr_accept;
  logic              rd_en, rd_last;
  logic [2*WIDTH-1:0] rd_data;

  logic             vld_p1, first_p1;
  logic             do_en_q, do_first_q;
  logic [WIDTH-1:0] do_re_q, do_im_q;

  assign wr_rev_full = bitrev(MAX_NN'(wr_cnt_q), NN);
  assign wr_rev      = wr_rev_full[NN-1:0];
  assign wr_done     = di_en & (&wr_cnt_q);

  // A completed bank is only committed if its buffer is free, or is being
  // released on this very edge (the set wins over the reader's clear).
  assign wr_accept = wr_done & (~full_q[wr_bank_q] | (rd_last & (rd_bank_q == wr_bank_q)));

  // The first address is issued in the same cycle rd_active is being set,
  // so a freshly filled bank reaches the output two edges after its last write.
  assign rd_en   = rd_active_q | full_q[rd_bank_q];
  assign rd_last = rd_en & (&rd_cnt_q);

  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    wr_bank_d   = wr_bank_q;
    rd_cnt_d    = rd_cnt_q;
    rd_bank_d   = rd_bank_q;
    full_d      = full_q;
    rd_active_d = rd_active_q;

    if (di_en) wr_cnt_d = wr_cnt_q + 1'b1;
    if (wr_accept) wr_bank_d = ~wr_bank_q;

    if (rd_en) rd_cnt_d = rd_cnt_q + 1'b1;
    if (rd_last) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    if (wr_accept) full_d[wr_bank_q] = 1'b1;

    rd_active_d = rd_en & (~rd_last | full_d[~rd_bank_q]);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      rd_active_q <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      rd_active_q <= rd_active_d;
    end
  end

  fft_reorder_ram #(
    .AW(NN + 1),
    .DW(2 * WIDTH)
  ) u_ram (
    .clk_i  (clock),
    .we_i   (di_en),
    .waddr_i({wr_bank_q, wr_rev}),
    .wdata_i({di_re, di_im}),
    .re_i   (rd_en),
    .raddr_i({rd_bank_q, rd_cnt_q}),
    .rdata_o(rd_data)
  );

  // p1: RAM read in flight; valid and frame-start flag track it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
    end else begin
      vld_p1   <= rd_en;
      first_p1 <= rd_en & (rd_cnt_q == '0);
    end
  end

  // p2: registered outputs; data holds while idle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      do_en_q    <= 1'b0;
      do_first_q <= 1'b0;
      do_re_q    <= '0;
      do_im_q    <= '0;
    end else begin
      do_en_q    <= vld_p1;
      do_first_q <= vld_p1 & first_p1;
      if (vld_p1) begin
        do_re_q <= rd_data[2*WIDTH-1:WIDTH];
        do_im_q <= rd_data[WIDTH-1:0];
      end
    end
  end

  assign do_en    = do_en_q;
  assign do_first = do_first_q;
  assign do_re    = do_re_q;
  assign do_im    = do_im_q;

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset) !(wr_done && !wr_accept));

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder: ramps, back-to-back, gaps, resets, FFT-like frames.
module tb_fft_bitrev_reorder;

  localparam int N = 128;
  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         di_en = 1'b0;
  logic [W-1:0] di_re = '0;
  logic [W-1:0] di_im = '0;
  logic         do_en, do_first;
  logic [W-1:0] do_re, do_im;

  fft_bitrev_reorder #(.N(N), .WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .di_en   (di_en),
    .di_re   (di_re),
    .di_im   (di_im),
    .do_en   (do_en),
    .do_re   (do_re),
    .do_im   (do_im),
    .do_first(do_first)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [W-1:0] q_re[$];
  logic [W-1:0] q_im[$];
  bit           q_first[$];
  int           q_cyc[$];

  always @(negedge clock) begin
    if (do_en) begin
      q_re.push_back(do_re);
      q_im.push_back(do_im);
      q_first.push_back(do_first);
      q_cyc.push_back(cyc);
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  int last_cap = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  function automatic int brev(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 7; i++) if (v[i]) r |= 1 << (6 - i);
    return r;
  endfunction

  // mode 0: ramp with per-frame offset; 1: impulse spectrum (flat); 2: DC spectrum
  function automatic logic [W-1:0] gen_re(input int mode, input int f, input int k);
    case (mode)
      0:       return W'(k + 'h1000 * f);
      1:       return W'('h1000);
      default: return (k == 0) ? W'('h1000) : W'(0);
    endcase
  endfunction

  function automatic logic [W-1:0] gen_im(input int mode, input int f, input int k);
    return (mode == 0) ? W'('h0100 + k + 'h1000 * f) : W'(0);
  endfunction

  task automatic clear_q();
    q_re.delete();
    q_im.delete();
    q_first.delete();
    q_cyc.delete();
  endtask

  task automatic send(input int nsamp, input int mode, input bit gap);
    for (int s = 0; s < nsamp; s++) begin
      @(negedge clock);
      if (gap && s > 0) begin
        di_en = 1'b0;
        @(negedge clock);
      end
      di_en = 1'b1;
      di_re = gen_re(mode, s / N, s % N);
      di_im = gen_im(mode, s / N, s % N);
    end
    @(negedge clock);
    di_en    = 1'b0;
    last_cap = cyc;
  endtask

  task automatic wait_out(input int cnt, input int budget);
    int i;
    i = 0;
    while (q_re.size() < cnt && i < budget) begin
      @(negedge clock);
      #1;
      i++;
    end
    repeat (10) @(negedge clock);
    #1;
  endtask

  task automatic check_stream(input string tag, input int nf, input int mode);
    int errs, n, f, k, sz;
    errs = 0;
    sz   = q_re.size();
    chk({tag, "_count"}, sz, nf * N);
    if (sz == nf * N) begin
      for (int i = 0; i < sz; i++) begin
        f = i / N;
        n = i % N;
        k = brev(n);
        if (q_re[i] !== gen_re(mode, f, k)) errs++;
        if (q_im[i] !== gen_im(mode, f, k)) errs++;
        if (q_first[i] !== (n == 0)) errs++;
      end
      chk({tag, "_data"}, errs, 0);
      chk({tag, "_contig"}, q_cyc[sz-1] - q_cyc[0], sz - 1);
    end
  endtask

  initial begin
    int sz;
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_do_en", do_en, 0);
    chk("rst_do_first", do_first, 0);
    chk("rst_do_re", do_re, 0);
    chk("rst_do_im", do_im, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // single ramp frame
    clear_q();
    send(N, 0, 1'b0);
    wait_out(N, 400);
    check_stream("ramp", 1, 0);
    if (q_re.size() == N) begin
      chk("ramp_lat", q_cyc[0] - last_cap, 2);
      chk("ramp_n0_re", q_re[0], 'h0000);
      chk("ramp_n0_im", q_im[0], 'h0100);
      chk("ramp_n1_re", q_re[1], 'h0040);
      chk("ramp_n1_im", q_im[1], 'h0140);
      chk("ramp_n2_re", q_re[2], 'h0020);
      chk("ramp_n2_im", q_im[2], 'h0120);
      chk("ramp_n127_re", q_re[127], 'h007F);
      chk("ramp_n127_im", q_im[127], 'h017F);
      chk("ramp_first0", q_first[0], 1);
    end

    // three frames back to back
    clear_q();
    send(3 * N, 0, 1'b0);
    wait_out(3 * N, 900);
    check_stream("b2b", 3, 0);
    if (q_re.size() == 3 * N) begin
      chk("b2b_first128", q_first[128], 1);
      chk("b2b_first256", q_first[256], 1);
      chk("b2b_f1_n1_re", q_re[129], 'h1040);
      chk("b2b_f2_n0_im", q_im[256], 'h2100);
    end

    // gapped input
    clear_q();
    send(N, 0, 1'b1);
    wait_out(N, 600);
    check_stream("gap", 1, 0);
    if (q_re.size() == N) chk("gap_lat", q_cyc[0] - last_cap, 2);

    // reset in the middle of a write frame; do_re is holding 0x007F here
    clear_q();
    send(60, 0, 1'b0);
    reset = 1'b0;
    #1;
    chk("rstmid_do_re", do_re, 0);
    chk("rstmid_do_im", do_im, 0);
    @(negedge clock);
    reset = 1'b1;
    send(N, 0, 1'b0);
    wait_out(N, 400);
    check_stream("rstmid", 1, 0);

    // reset during readout at output index 50
    clear_q();
    send(N, 0, 1'b0);
    for (int i = 0; i < 300 && q_re.size() < 51; i++) begin
      @(negedge clock);
      #1;
    end
    reset = 1'b0;
    #1;
    chk("rdrst_do_en", do_en, 0);
    chk("rdrst_do_first", do_first, 0);
    chk("rdrst_do_re", do_re, 0);
    @(negedge clock);
    reset = 1'b1;
    sz = q_re.size();
    chk("rdrst_idx", sz, 51);
    repeat (200) @(negedge clock);
    #1;
    chk("rdrst_quiet", q_re.size(), sz);
    clear_q();
    send(N, 0, 1'b0);
    wait_out(N, 400);
    check_stream("rdrst_next", 1, 0);

    // FFT-like frames: impulse response is flat, DC is bin 0 only
    clear_q();
    send(N, 1, 1'b0);
    wait_out(N, 400);
    check_stream("imp", 1, 1);
    clear_q();
    send(N, 2, 1'b0);
    wait_out(N, 400);
    check_stream("dc", 1, 2);
    if (q_re.size() == N) begin
      chk("dc_bin0_re", q_re[0], 'h1000);
      chk("dc_bin0_first", q_first[0], 1);
      chk("dc_bin1_re", q_re[1], 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d of %0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Sits directly downstream of the R22SDF FFT core.
- The FFT emits each N-point frame in bit-reversed index order. This block consumes that stream (do_en/do_re/do_im of the FFT) and re-emits every frame in natural order.
- Uses a ping-pong double buffer, so back-to-back frames flow with no gap and no input stall.

Parameters:
- N, 128: FFT point count; power of 2, 4..4096.
- WIDTH, 16: bit width of each real/imag sample.
- NN, log2(N) (localparam): address/count width.

Ports:
- clock, in, 1: sole clock; rising-edge.
- reset, in, 1: asynchronous, active-low reset.
- di_en, in, 1: input sample valid (driven by the FFT do_en).
- di_re, in, WIDTH: input real part, bit-reversed order.
- di_im, in, WIDTH: input imaginary part.
- do_en, out, 1: output sample valid.
- do_re, out, WIDTH: output real part, natural order.
- do_im, out, WIDTH: output imaginary part.
- do_first, out, 1: high with do_en on output index 0 of each frame.

Behaviour:
- Reset (reset low, asynchronous):
  - wr_cnt=0, wr_bank=0, rd_cnt=0, rd_bank=0, both bank_full flags=0, rd_active=0.
  - do_en=0, do_first=0, do_re=0, do_im=0.
  - RAM contents are not cleared. Any partial frame is discarded.
- Write side:
  - Each clock with di_en=1, the sample is written to RAM address {wr_bank, bitrev(wr_cnt)}, then wr_cnt increments.
  - di_en may have gaps. Samples are counted, not cycles.
  - When wr_cnt=N-1 is written: wr_cnt wraps to 0, bank_full[wr_bank] sets, wr_bank toggles.
- Read side:
  - When rd_active=0 and bank_full[rd_bank]=1, rd_active sets on the next edge.
  - While rd_active=1, read address {rd_bank, rd_cnt} is issued every clock and rd_cnt increments.
  - On issuing rd_cnt=N-1: bank_full[rd_bank] clears, rd_bank toggles, rd_cnt wraps to 0.
  - If the new rd_bank is already full, rd_active stays 1, giving seamless continuation. Otherwise rd_active clears.
- Latency:
  - RAM read is synchronous (1 cycle). do_re/do_im/do_en/do_first are registered (1 more cycle).
  - If edge E captures input sample N-1, output index 0 appears with do_en=1 after edge E+2.
  - Output is N contiguous do_en cycles per frame.
- Ordering: output index n = input sample bitrev_NN(n).
- Simultaneous events:
  - Writer setting bank_full[b] and reader clearing bank_full[b'] on the same edge are independent (b≠b' by construction).
  - If the same flag would be both set and cleared on one edge, set wins.
- Overflow:
  - Unreachable while input rate ≤1 sample/clock, because the reader drains N in N cycles.
  - If the writer completes a bank whose bank_full is still 1, that frame is dropped: flag unchanged, write bank not toggled.
  - This case is covered by an assertion, not by a port.
- do_en=0 forces do_first=0. do_re/do_im hold their last value when do_en=0.

Decomposition:
- fft_pkg (shared):
  - log2 constant function.
  - Default WIDTH and N.
  - bitrev function (parameterised width, returns reversed count).
- One sub-module: fft_reorder_ram.
  - Simple dual-port: 1 write port, 1 synchronous read port.
  - Depth 2N, data 2*WIDTH (re,im packed); address MSB = bank.
  - Inferable as block RAM.

Test Plan:
- Ramp, one frame:
  - Stimulus: di_re=k, di_im=0x0100+k for k=0..127, contiguous.
  - Required: do_en high 128 cycles starting 2 edges after the last capture; do_first on the first output only.
  - Required values: n=0 → (0x0000,0x0100); n=1 → (0x0040,0x0140); n=2 → (0x0020,0x0120); n=127 → (0x007F,0x017F).
- Back-to-back frames:
  - Stimulus: three ramp frames, 384 contiguous di_en cycles, frame f offset by 0x1000*f.
  - Required: do_en high for exactly 384 contiguous cycles; do_first at output cycles 0, 128, 256; values correct per bank.
- Gapped input:
  - Stimulus: same ramp with di_en toggling 1,0,1,0.
  - Required: output identical to the single-frame ramp; first output 2 edges after the 128th valid sample.
- Reset mid-frame:
  - Stimulus: 60 samples, reset low for 1 cycle, then a full ramp frame.
  - Required: outputs go to 0 asynchronously; only one frame is output, matching the ramp; no output from the partial frame.
- Reset during readout:
  - Stimulus: assert reset at output index 50.
  - Required: do_en=0 immediately and stays 0 until the next full frame is written.
- Integration with the FFT core:
  - Stimulus: impulse at input 0 (re=0x1000), then a DC frame.
  - Required: impulse gives all natural-order bins equal; DC gives energy only at output n=0, with do_first coincident.
